// File: rtl/imem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : imem_pkg                                                     |
// | Purpose  : Shared constants and enums for the loadable instruction      |
// |            memory (NOP fill word, fault codes, controller states).      |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
package imem_pkg;

   // addi x0,x0,0 -- used to clear the array and as the fault response word
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      FLT_NONE     = 2'b00,
      FLT_MISALIGN = 2'b01,
      FLT_RANGE    = 2'b10
   } fault_t;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : imem_ram                                                     |
// | Purpose  : Simple dual-port RAM, one write port and one synchronous     |
// |            read-first read port, both on clk. The array is not reset.   |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module imem_ram #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write and read in the same non-blocking block: a same-address read sees the old word
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : imem_loadable                                                |
// | Purpose  : Loadable instruction memory for the fetch path. Clears the   |
// |            array to NOP after reset, accepts word loads, and serves     |
// |            registered, handshaked fetches with fault reporting.         |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module imem_loadable
   import imem_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int          DEPTH     = 64,
   parameter logic [31:0] FILL_WORD = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [$clog2(DEPTH)-1:0] ld_idx,
   input  logic [DATA_W-1:0]        ld_data,
   input  logic                     fe_valid,
   output logic                     fe_ready,
   input  logic [ADDR_W-1:0]        fe_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_instr,
   output logic [1:0]               rsp_fault,
   output logic [ADDR_W-1:0]        rsp_addr
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] FILL = FILL_WORD[DATA_W-1:0];

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  init_cnt;
   logic              init_we;
   logic              ld_accept;
   logic              fe_accept;
   fault_t            fe_fault;
   logic              ram_we;
   logic [IDX_W-1:0]  ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              rsp_from_ram;
   logic [DATA_W-1:0] rsp_word;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave INIT once the last word has been cleared
   always_comb begin
      state_nxt = state;
      if (state == INIT && init_cnt == LAST_IDX) begin
         state_nxt = RUN;
      end
   end

   // Outputs of the controller: handshake readies depend only on state and response handshake
   always_comb begin
      init_we  = 1'b0;
      ld_ready = 1'b0;
      fe_ready = 1'b0;
      if (state == INIT) begin
         init_we = 1'b1;
      end else begin
         ld_ready = 1'b1;
         fe_ready = !rsp_valid || rsp_ready;
      end
   end

   // Clear counter walks every word while in INIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_cnt <= '0;
      end else if (state == INIT) begin
         init_cnt <= init_cnt + 1'b1;
      end
   end

   assign ld_accept = ld_valid && ld_ready;
   assign fe_accept = fe_valid && fe_ready;

   // Write port mux and fault decode; misalignment outranks range
   always_comb begin
      ram_we    = ld_accept;
      ram_waddr = ld_idx;
      ram_wdata = ld_data;
      if (init_we) begin
         ram_we    = 1'b1;
         ram_waddr = init_cnt;
         ram_wdata = FILL;
      end
      fe_fault = FLT_NONE;
      if (fe_addr[1:0] != 2'b00) begin
         fe_fault = FLT_MISALIGN;
      end else if ((fe_addr >> (IDX_W + 2)) != '0) begin
         fe_fault = FLT_RANGE;
      end
   end

   imem_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (fe_accept && fe_fault == FLT_NONE),
      .raddr (fe_addr[IDX_W+1:2]),
      .rdata (ram_rdata)
   );

   // Response register: load on accept, drop valid on drain, otherwise hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid    <= 1'b0;
         rsp_fault    <= FLT_NONE;
         rsp_addr     <= '0;
         rsp_from_ram <= 1'b0;
         rsp_word     <= '0;
      end else if (fe_accept) begin
         rsp_valid    <= 1'b1;
         rsp_fault    <= fe_fault;
         rsp_addr     <= fe_addr;
         rsp_from_ram <= (fe_fault == FLT_NONE);
         rsp_word     <= FILL;
      end else if (rsp_ready) begin
         rsp_valid    <= 1'b0;
      end
   end

   // The RAM read register only updates on a non-faulting accept, so it holds with the response
   assign rsp_instr = rsp_from_ram ? ram_rdata : rsp_word;

endmodule
`default_nettype wire
